// File: rtl/fmul_iter.sv
// fmul_iter: iterative IEEE-754 multiplier (N=32 or 64), flush-to-zero, round-to-nearest-even.
// Ports: clk, rst (sync, active-high); in_valid/in_ready + a/b operand handshake;
//        out_valid/out_ready + out/flags {invalid, overflow, underflow, inexact} result handshake.
module fmul_iter #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out,
    output logic [3:0]   flags
);
    localparam int EXP_W  = (N == 64) ? 11 : 8;
    localparam int FRAC_W = N - EXP_W - 1;
    localparam int M      = FRAC_W + 1;
    localparam int BIAS   = 2 ** (EXP_W - 1) - 1;
    localparam int CW     = $clog2(FRAC_W + 2);
    localparam int EW     = EXP_W + 2;
    localparam logic [EW-1:0] EMAX = EW'(2 ** EXP_W - 1);
    localparam logic [N-1:0]  QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_t;

    state_t         state_q;
    logic [CW-1:0]  cnt_q;
    logic [M-1:0]   ma_q;
    logic [2*M-1:0] p_q;
    logic [EW-1:0]  es_q;
    logic           sign_q, in_ready_q, out_valid_q;
    logic [N-1:0]   out_q;
    logic [3:0]     flags_q;

    logic [EXP_W-1:0]  ea, eb;
    logic [FRAC_W-1:0] fa, fb;
    logic              a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, snan, nan_inv, special, sign_in;
    logic [N-1:0]      spec_out;
    logic [3:0]        spec_flags;
    logic [EW-1:0]     es_d;

    assign ea         = a[N-2 -: EXP_W];
    assign eb         = b[N-2 -: EXP_W];
    assign fa         = a[FRAC_W-1:0];
    assign fb         = b[FRAC_W-1:0];
    // a zero exponent covers both zero and subnormals, which are flushed to zero
    assign a_zero     = ~|ea;
    assign b_zero     = ~|eb;
    assign a_inf      = &ea && ~|fa;
    assign b_inf      = &eb && ~|fb;
    assign a_nan      = &ea && |fa;
    assign b_nan      = &eb && |fb;
    assign snan       = (a_nan && !fa[FRAC_W-1]) || (b_nan && !fb[FRAC_W-1]);
    assign nan_inv    = a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf);
    assign special    = nan_inv || a_inf || b_inf || a_zero || b_zero;
    assign sign_in    = a[N-1] ^ b[N-1];
    assign spec_out   = nan_inv ? QNAN : {sign_in, {EXP_W{a_inf || b_inf}}, {FRAC_W{1'b0}}};
    assign spec_flags = {snan || (nan_inv && !a_nan && !b_nan), 3'b000};
    assign es_d       = EW'(ea) + EW'(eb) - EW'(BIAS);

    // shift-add step: low half of p_q holds the unconsumed multiplier bits
    logic [M:0] sum;
    assign sum = {1'b0, p_q[2*M-1:M]} + {1'b0, p_q[0] ? ma_q : {M{1'b0}}};

    logic              norm_sh, guard, sticky, up, rc, ovf, unf, inexact;
    logic [FRAC_W-1:0] frac;
    logic [FRAC_W:0]   fr;
    logic [EW-1:0]     e;
    logic [N-1:0]      norm_out;
    logic [3:0]        norm_flags;

    assign norm_sh    = p_q[2*M-1];
    assign frac       = norm_sh ? p_q[2*M-2:M] : p_q[2*M-3:M-1];
    assign guard      = norm_sh ? p_q[M-1] : p_q[M-2];
    assign sticky     = norm_sh ? |p_q[M-2:0] : |p_q[M-3:0];
    assign up         = guard && (sticky || frac[0]);
    // a carry out of the fraction leaves it all-zero, which is the renormalised 1.0 x 2
    assign fr         = {1'b0, frac} + {{FRAC_W{1'b0}}, up};
    assign rc         = fr[FRAC_W];
    assign e          = es_q + EW'(norm_sh) + EW'(rc);
    assign ovf        = !e[EW-1] && e >= EMAX;
    assign unf        = e[EW-1] || e == '0;
    assign inexact    = guard || sticky;
    assign norm_out   = ovf ? {sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}} :
                        unf ? {sign_q, {(N-1){1'b0}}} : {sign_q, e[EXP_W-1:0], fr[FRAC_W-1:0]};
    assign norm_flags = ovf ? 4'b0101 : unf ? 4'b0011 : {3'b000, inexact};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            flags_q     <= '0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    in_ready_q <= 1'b0;
                    if (special) begin
                        out_q       <= spec_out;
                        flags_q     <= spec_flags;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        ma_q    <= {1'b1, fa};
                        p_q     <= {{M{1'b0}}, 1'b1, fb};
                        es_q    <= es_d;
                        sign_q  <= sign_in;
                        state_q <= MUL;
                    end
                end
                MUL: begin
                    p_q   <= {sum, p_q[M-1:1]};
                    cnt_q <= (cnt_q == CW'(FRAC_W)) ? '0 : cnt_q + 1'b1;
                    if (cnt_q == CW'(FRAC_W)) state_q <= NORM;
                end
                NORM: begin
                    out_q       <= norm_out;
                    flags_q     <= norm_flags;
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: if (out_ready) begin
                    out_q       <= '0;
                    flags_q     <= '0;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out       = out_q;
    assign flags     = flags_q;
endmodule

// File: tb/tb_fmul_iter.sv
// tb_fmul_iter: scoreboard bench for fmul_iter at N=32 and N=64 with directed vectors.
module tb_fmul_iter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        iv32, ir32, ov32, or32;
    logic [31:0] a32, b32, o32;
    logic [3:0]  f32;
    logic        iv64, ir64, ov64, or64;
    logic [63:0] a64, b64, o64;
    logic [3:0]  f64;

    fmul_iter #(.N(32)) dut32 (.clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32),
                               .out_valid(ov32), .out_ready(or32), .out(o32), .flags(f32));
    fmul_iter #(.N(64)) dut64 (.clk(clk), .rst(rst), .in_valid(iv64), .in_ready(ir64), .a(a64), .b(b64),
                               .out_valid(ov64), .out_ready(or64), .out(o64), .flags(f64));

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [63:0] o;
        logic [3:0]  f;
        int          lat;
        int          acc;
    } exp_t;

    exp_t q32[$];
    exp_t q64[$];
    exp_t e32, e64;
    logic pv32 = 1'b0, pv64 = 1'b0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, want);
        end
    endfunction

    // latency = edges from the accept edge to the edge that raises out_valid
    always @(negedge clk) begin
        if (ov32 && !pv32) begin
            if (q32.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_out32: got %h, want no result", o32);
            end else begin
                e32 = q32.pop_front();
                chk("out32", {32'b0, o32}, e32.o);
                chk("flags32", {60'b0, f32}, {60'b0, e32.f});
                chk("lat32", 64'(cyc - e32.acc), 64'(e32.lat));
            end
        end
        pv32 = ov32;
    end

    always @(negedge clk) begin
        if (ov64 && !pv64) begin
            if (q64.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_out64: got %h, want no result", o64);
            end else begin
                e64 = q64.pop_front();
                chk("out64", o64, e64.o);
                chk("flags64", {60'b0, f64}, {60'b0, e64.f});
                chk("lat64", 64'(cyc - e64.acc), 64'(e64.lat));
            end
        end
        pv64 = ov64;
    end

    task automatic issue(input bit wide, input logic [63:0] av, input logic [63:0] bv,
                         input logic [63:0] eo, input logic [3:0] ef, input int lat, input bit track);
        int t = 0;
        exp_t x;
        @(negedge clk);
        while (!(wide ? ir64 : ir32) && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) begin
            n_vec++;
            n_err++;
            $display("FAIL issue_timeout: in_ready stayed %b, want 1", wide ? ir64 : ir32);
            return;
        end
        if (wide) begin
            a64 = av; b64 = bv; iv64 = 1'b1;
        end else begin
            a32 = av[31:0]; b32 = bv[31:0]; iv32 = 1'b1;
        end
        @(posedge clk);
        #1;
        x.o = eo; x.f = ef; x.lat = lat; x.acc = cyc;
        if (wide) begin
            iv64 = 1'b0; a64 = {$urandom, $urandom}; b64 = {$urandom, $urandom};
            if (track) q64.push_back(x);
        end else begin
            iv32 = 1'b0; a32 = $urandom; b32 = $urandom;
            if (track) q32.push_back(x);
        end
    endtask

    task automatic drain();
        int t = 0;
        while ((q32.size() != 0 || q64.size() != 0 || !ir32 || !ir64) && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout: %0d/%0d results outstanding, want 0", q32.size(), q64.size());
        end
    endtask

    initial begin
        int t;
        rst = 1'b1; or32 = 1'b1; or64 = 1'b1;
        iv32 = 1'b1; a32 = 32'h3FC00000; b32 = 32'h40000000;
        iv64 = 1'b0; a64 = '0; b64 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", {63'b0, ir32}, 64'd1);
        chk("rst_out_valid", {63'b0, ov32}, 64'd0);
        chk("rst_out", {32'b0, o32}, 64'd0);
        chk("rst_flags", {60'b0, f32}, 64'd0);
        chk("rst_in_ready64", {63'b0, ir64}, 64'd1);
        iv32 = 1'b0;
        rst = 1'b0;

        // normal path: 25 edges; specials decided and registered on the accept edge itself
        issue(0, 64'h3FC00000, 64'h40000000, 64'h40400000, 4'b0000, 25, 1);
        issue(0, 64'h7F800000, 64'h00000000, 64'h7FC00000, 4'b1000, 0, 1);
        issue(0, 64'h7F000000, 64'h40000000, 64'h7F800000, 4'b0101, 25, 1);
        issue(0, 64'h3F800001, 64'h3F800001, 64'h3F800002, 4'b0001, 25, 1);
        issue(0, 64'h00800000, 64'h3F000000, 64'h00000000, 4'b0011, 25, 1);
        issue(0, 64'h7F800001, 64'h3F800000, 64'h7FC00000, 4'b1000, 0, 1);
        issue(0, 64'h7FC00000, 64'h40000000, 64'h7FC00000, 4'b0000, 0, 1);
        issue(0, 64'hFF800000, 64'h40000000, 64'hFF800000, 4'b0000, 0, 1);
        issue(0, 64'h00000001, 64'hC0400000, 64'h80000000, 4'b0000, 0, 1);
        issue(0, 64'h40400000, 64'h40400000, 64'h41100000, 4'b0000, 25, 1);
        issue(0, 64'h3FC00000, 64'h3F800001, 64'h3FC00002, 4'b0001, 25, 1);
        issue(0, 64'h3FC00000, 64'h3F800003, 64'h3FC00004, 4'b0001, 25, 1);
        // significands 2351*4513 and 13264529 multiply to 2^47-1: rounds up with a fraction carry
        issue(0, 64'h3FA1E58F, 64'h3FCA6691, 64'h40000000, 4'b0001, 25, 1);
        issue(1, 64'h3FF8000000000000, 64'h4000000000000000, 64'h4008000000000000, 4'b0000, 54, 1);
        issue(1, 64'h7FF0000000000000, 64'h0000000000000000, 64'h7FF8000000000000, 4'b1000, 0, 1);
        drain();

        or32 = 1'b0;
        issue(0, 64'h40000000, 64'h40400000, 64'h40C00000, 4'b0000, 25, 1);
        t = 0;
        while (!ov32 && t < 100) begin
            @(negedge clk);
            t++;
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_out", {32'b0, o32}, 64'h40C00000);
            chk("bp_flags", {60'b0, f32}, 64'd0);
            chk("bp_valid", {63'b0, ov32}, 64'd1);
            chk("bp_in_ready", {63'b0, ir32}, 64'd0);
            iv32 = ~iv32;
            a32 = 32'h3F800000;
            b32 = $urandom;
        end
        @(negedge clk);
        iv32 = 1'b0;
        or32 = 1'b1;
        @(negedge clk);
        chk("bp_rel_valid", {63'b0, ov32}, 64'd0);
        chk("bp_rel_out", {32'b0, o32}, 64'd0);
        chk("bp_rel_flags", {60'b0, f32}, 64'd0);
        chk("bp_rel_in_ready", {63'b0, ir32}, 64'd1);
        drain();

        issue(0, 64'h3FC00000, 64'h40000000, 64'h0, 4'b0000, 0, 0);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_valid", {63'b0, ov32}, 64'd0);
        chk("abort_out", {32'b0, o32}, 64'd0);
        chk("abort_in_ready", {63'b0, ir32}, 64'd1);
        issue(0, 64'hC0000000, 64'h40400000, 64'hC0C00000, 4'b0000, 25, 1);
        drain();
        repeat (30) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
